// File: rtl/spi_frame_rx_pkg.sv
// spi_frame_rx_pkg: shared defaults and FSM state encoding for the dual-lane SPI frame receiver
package spi_frame_rx_pkg;
   localparam int NBITS_DEF = 32;
   localparam int CNT_W_DEF = 16;
   typedef enum logic [1:0] {WAIT_HIGH, IDLE, SHIFT} state_t;
endpackage

// File: rtl/spi_frame_rx_sync.sv
// sync_edge: multi-flop synchroniser plus history flop, giving level, rise and fall per bit
module sync_edge #(
   parameter int STAGES = 2,
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] din,
   output logic [W-1:0] level,
   output logic [W-1:0] rise,
   output logic [W-1:0] fall
);
   logic [W-1:0] sync [STAGES];
   logic [W-1:0] hist;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int i = 0; i < STAGES; i++) sync[i] <= '0;
         hist <= '0;
      end else begin
         sync[0] <= din;
         for (int i = 1; i < STAGES; i++) sync[i] <= sync[i-1];
         hist <= sync[STAGES-1];
      end
   assign level = sync[STAGES-1];
   assign rise = level & ~hist;
   assign fall = ~level & hist;
endmodule

// File: rtl/spi_frame_rx.sv
// spi_frame_rx: dual-lane SPI frame receiver; commits a word pair only on a well-formed frame
module spi_frame_rx
   import spi_frame_rx_pkg::*;
#(
   parameter int NBITS = NBITS_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             sck,
   input  logic             ssel,
   input  logic             data_in0,
   input  logic             data_in1,
   output logic [NBITS-1:0] rx_out0,
   output logic [NBITS-1:0] rx_out1,
   output logic             rdy,
   output logic             valid,
   output logic             frame_err,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] err_cnt
);
   localparam int BW = $clog2(NBITS + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   state_t state, state_nxt;
   logic sck_rise, ssel_lvl, ssel_rise, ssel_fall;
   logic sck_unused_lvl, sck_unused_fall;
   logic [1:0] data, data_rise_unused, data_fall_unused;
   logic [NBITS-1:0] sr0, sr1;
   logic [BW-1:0] bit_cnt;
   logic [TW-1:0] tmo_cnt;
   logic overrun, start, commit, reject;
   sync_edge #(.STAGES(SYNC_STAGES), .W(1)) u_sck (
      .clk(clk), .reset(reset), .din(sck),
      .level(sck_unused_lvl), .rise(sck_rise), .fall(sck_unused_fall)
   );
   sync_edge #(.STAGES(SYNC_STAGES), .W(1)) u_ssel (
      .clk(clk), .reset(reset), .din(ssel),
      .level(ssel_lvl), .rise(ssel_rise), .fall(ssel_fall)
   );
   sync_edge #(.STAGES(SYNC_STAGES), .W(2)) u_data (
      .clk(clk), .reset(reset), .din({data_in1, data_in0}),
      .level(data), .rise(data_rise_unused), .fall(data_fall_unused)
   );
   always_comb begin
      state_nxt = state;
      start = 1'b0;
      commit = 1'b0;
      reject = 1'b0;
      case (state)
         WAIT_HIGH: state_nxt = ssel_lvl ? IDLE : WAIT_HIGH;
         IDLE: begin
            start = en && ssel_fall;
            state_nxt = start ? SHIFT : IDLE;
         end
         SHIFT:
            if (!en) state_nxt = WAIT_HIGH;
            else if (ssel_rise) begin
               state_nxt = IDLE;
               commit = (bit_cnt == BW'(NBITS)) && !overrun;
               reject = !commit;
            end else if (tmo_cnt >= TW'(TIMEOUT)) begin
               state_nxt = WAIT_HIGH;
               reject = 1'b1;
            end
         default: state_nxt = WAIT_HIGH;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= WAIT_HIGH;
         sr0 <= '0;
         sr1 <= '0;
         bit_cnt <= '0;
         tmo_cnt <= '0;
         overrun <= 1'b0;
         rx_out0 <= '0;
         rx_out1 <= '0;
         rdy <= 1'b0;
         valid <= 1'b0;
         frame_err <= 1'b0;
         frame_cnt <= '0;
         err_cnt <= '0;
      end else begin
         state <= state_nxt;
         rdy <= commit;
         frame_err <= reject;
         if (start) begin
            sr0 <= '0;
            sr1 <= '0;
            bit_cnt <= '0;
            tmo_cnt <= '0;
            overrun <= 1'b0;
         end else if (state == SHIFT) begin
            // an SCK edge coinciding with the closing ssel edge is not part of the frame
            if (sck_rise && !ssel_rise) begin
               tmo_cnt <= '0;
               if (bit_cnt == BW'(NBITS)) overrun <= 1'b1;
               else begin
                  sr0 <= {sr0[NBITS-2:0], data[0]};
                  sr1 <= {sr1[NBITS-2:0], data[1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end else tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (commit) begin
            rx_out0 <= sr0;
            rx_out1 <= sr1;
            valid <= 1'b1;
            if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
         end
         if (reject && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
endmodule
